// File: rtl/net_tx_queue_if.sv
// Packet type and the push/pop handshake bundle shared by the transmit queue and its neighbours.
// Push side has no backpressure; pop side uses valid/ready.
package net_tx_pkg;
  typedef struct packed {
    logic [15:0] conn_id;
    logic [15:0] length;
    logic [31:0] payload;
  } NetworkPacketInternal;
endpackage

interface net_tx_queue_if #(parameter int LOG_DEPTH = 3);
  import net_tx_pkg::*;

  NetworkPacketInternal   pkt_in;
  logic                   pkt_valid_in;
  NetworkPacketInternal   pkt_out;
  logic                   pkt_valid_out;
  logic                   pkt_ready_in;
  logic [LOG_DEPTH:0]     fill_level;
  logic                   almost_full;
  logic [31:0]            drop_cnt;

  modport master (
    output pkt_in, pkt_valid_in, pkt_ready_in,
    input  pkt_out, pkt_valid_out, fill_level, almost_full, drop_cnt
  );

  modport slave (
    input  pkt_in, pkt_valid_in, pkt_ready_in,
    output pkt_out, pkt_valid_out, fill_level, almost_full, drop_cnt
  );
endinterface

// File: rtl/net_tx_queue.sv
// TX packet queue, 2^LOG_DEPTH deep: head visible the cycle after push, 1 pkt/cycle; overflow drops
// the incoming packet (no upstream backpressure). NET_TX_QUEUE_DROP_CNT_EN enables the drop counter.
module net_tx_queue
  import net_tx_pkg::*;
#(
  parameter logic [31:0] NIC_ID    = 32'h0,
  parameter int          LOG_DEPTH = 3
) (
  input  logic           clk,
  input  logic           reset,
  net_tx_queue_if.slave  q
);
  localparam int                   DEPTH     = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   CNT_DEPTH = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE   = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_TWO   = (LOG_DEPTH + 1)'(2);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);

  typedef enum logic {ST_EMPTY, ST_FULL} out_state_t;

  out_state_t             state_q, state_d;
  NetworkPacketInternal   mem [DEPTH];
  NetworkPacketInternal   pkt_out_q, pkt_out_d;
  logic [LOG_DEPTH-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [LOG_DEPTH:0]     count_q, count_d;
  logic                   almost_full_q;
  logic                   push, pop, drop;

  // The memory holds every queued packet including the head; pkt_out is a registered copy of it.
  assign pop     = (state_q == ST_FULL) && q.pkt_ready_in;
  assign drop    = q.pkt_valid_in && (count_q == CNT_DEPTH);
  assign push    = q.pkt_valid_in && !drop;
  assign rd_next = rd_ptr + PTR_ONE;

  always_comb begin
    state_d   = state_q;
    pkt_out_d = pkt_out_q;
    count_d   = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          pkt_out_d = q.pkt_in;
          state_d   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (pop) begin
          if (count_q >= CNT_TWO) begin
            pkt_out_d = mem[rd_next];
          end else if (push) begin
            pkt_out_d = q.pkt_in;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      pkt_out_q     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pkt_out_q     <= pkt_out_d;
      count_q       <= count_d;
      almost_full_q <= (count_d >= (CNT_DEPTH - CNT_TWO));
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= q.pkt_in;
  end

`ifdef NET_TX_QUEUE_DROP_CNT_EN
  logic [31:0] drop_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end
  assign q.drop_cnt = drop_cnt_q;
`else
  assign q.drop_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && drop) $display("net_tx_queue nic %0h: drop conn_id %0d", NIC_ID, q.pkt_in.conn_id);
  end
`endif

  assign q.pkt_out       = pkt_out_q;
  assign q.pkt_valid_out = (state_q == ST_FULL);
  assign q.fill_level    = count_q;
  assign q.almost_full   = almost_full_q;
endmodule

// File: tb/tb_net_tx_queue.sv
// Self-checking bench for net_tx_queue: directed tables, corner sequences and random traffic vs a queue model.
module tb_net_tx_queue;
  import net_tx_pkg::*;

  localparam int LOG_DEPTH = 3;
  localparam int DEPTH     = 1 << LOG_DEPTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  net_tx_queue_if #(.LOG_DEPTH(LOG_DEPTH)) bus ();

  net_tx_queue #(.NIC_ID(32'h0), .LOG_DEPTH(LOG_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  NetworkPacketInternal mq[$];
  longint               m_drops = 0;

  typedef struct {
    logic        v;
    logic [15:0] cid;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_cid;
    int          exp_fill;
    logic        exp_af;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_drop_cnt();
`ifdef NET_TX_QUEUE_DROP_CNT_EN
    return (m_drops > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_drops[31:0];
`else
    return 32'h0;
`endif
  endfunction

  task automatic check_model();
    chk("valid_vs_model", 64'(bus.pkt_valid_out), 64'(mq.size() > 0));
    chk("fill_vs_model", 64'(bus.fill_level), 64'(mq.size()));
    chk("af_vs_model", 64'(bus.almost_full), 64'(mq.size() >= DEPTH - 2));
    chk("drop_vs_model", 64'(bus.drop_cnt), 64'(exp_drop_cnt()));
    if (mq.size() > 0) chk("head_vs_model", 64'(bus.pkt_out), 64'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare on the falling edge.
  task automatic step(input logic v, input logic [15:0] cid, input logic rdy, input logic rst);
    NetworkPacketInternal p;
    bit pop_ok, acc;
    p.conn_id = cid;
    p.length  = 16'($urandom);
    p.payload = $urandom;
    bus.pkt_in       = p;
    bus.pkt_valid_in = v;
    bus.pkt_ready_in = rdy;
    reset            = rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_drops = 0;
    end else begin
      pop_ok = (mq.size() > 0) && rdy;
      acc    = v && (mq.size() < DEPTH);
      if (v && !acc) m_drops++;
      if (pop_ok) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    step(1'b0, 16'd0, 1'b0, 1'b1);
    step(1'b0, 16'd0, 1'b0, 1'b1);
    chk("reset_pkt_out", 64'(bus.pkt_out), 64'd0);
    step(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.pkt_in       = '0;
    bus.pkt_valid_in = 1'b0;
    bus.pkt_ready_in = 1'b0;
    reset            = 1'b1;

    // Basic latency, then stalled fill and in-order drain.
    tbl.push_back('{1'b1, 16'd5, 1'b1, 1'b1, 16'd5, 1, 1'b0});
    tbl.push_back('{1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 0, 1'b0});
    for (int i = 0; i < DEPTH; i++)
      tbl.push_back('{1'b1, 16'(i), 1'b0, 1'b1, 16'd0, i + 1, (i + 1) >= DEPTH - 2});
    for (int j = 0; j < DEPTH; j++)
      tbl.push_back('{1'b0, 16'd0, 1'b1, j < DEPTH - 1, 16'(j + 1), DEPTH - 1 - j,
                      (DEPTH - 1 - j) >= DEPTH - 2});

    do_reset();
    chk("reset_valid", 64'(bus.pkt_valid_out), 64'd0);
    chk("reset_fill", 64'(bus.fill_level), 64'd0);
    chk("reset_drop", 64'(bus.drop_cnt), 64'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].v, tbl[k].cid, tbl[k].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", k), 64'(bus.pkt_valid_out), 64'(tbl[k].exp_v));
      chk($sformatf("tbl%0d_fill", k), 64'(bus.fill_level), 64'(tbl[k].exp_fill));
      chk($sformatf("tbl%0d_af", k), 64'(bus.almost_full), 64'(tbl[k].exp_af));
      if (tbl[k].exp_v) chk($sformatf("tbl%0d_cid", k), 64'(bus.pkt_out.conn_id), 64'(tbl[k].exp_cid));
    end

    // Overflow while stalled, then a push at the full boundary together with a pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'(10 + i), 1'b0, 1'b0);
    chk("ovf_fill", 64'(bus.fill_level), 64'(DEPTH));
`ifdef NET_TX_QUEUE_DROP_CNT_EN
    chk("ovf_drop", 64'(bus.drop_cnt), 64'd3);
`else
    chk("ovf_drop", 64'(bus.drop_cnt), 64'd0);
`endif
    chk("ovf_head", 64'(bus.pkt_out.conn_id), 64'd0);
    step(1'b1, 16'd13, 1'b1, 1'b0);
    chk("bnd_fill", 64'(bus.fill_level), 64'(DEPTH - 1));
`ifdef NET_TX_QUEUE_DROP_CNT_EN
    chk("bnd_drop", 64'(bus.drop_cnt), 64'd4);
`else
    chk("bnd_drop", 64'(bus.drop_cnt), 64'd0);
`endif
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("bnd_order%0d", i), 64'(bus.pkt_out.conn_id), 64'(i));
      step(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("bnd_drained", 64'(bus.pkt_valid_out), 64'd0);

    // Back-to-back streaming across several pointer wraps.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'(100 + i), 1'b1, 1'b0);
      chk($sformatf("wrap_cid%0d", i), 64'(bus.pkt_out.conn_id), 64'(100 + i));
      chk($sformatf("wrap_fill%0d", i), 64'(bus.fill_level <= 1), 64'd1);
    end
    step(1'b0, 16'd0, 1'b1, 1'b0);
    chk("wrap_empty", 64'(bus.pkt_valid_out), 64'd0);
    chk("wrap_drop", 64'(bus.drop_cnt), 64'd0);

    // Reset with packets queued; a push during reset must be ignored.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(20 + i), 1'b0, 1'b0);
    chk("mid_fill5", 64'(bus.fill_level), 64'd5);
    step(1'b1, 16'd77, 1'b0, 1'b1);
    chk("mid_valid", 64'(bus.pkt_valid_out), 64'd0);
    chk("mid_fill", 64'(bus.fill_level), 64'd0);
    chk("mid_pkt_out", 64'(bus.pkt_out), 64'd0);
    step(1'b1, 16'd9, 1'b0, 1'b0);
    chk("mid_first_cid", 64'(bus.pkt_out.conn_id), 64'd9);
    chk("mid_first_valid", 64'(bus.pkt_valid_out), 64'd1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
